// File: rtl/fpgaboy_clock_gen_if.sv
// rtl/fpgaboy_clock_gen_if.sv - switch inputs and generated clock/reset outputs of fpgaboy_clock_gen
interface fpgaboy_clock_gen_if;
  logic sw_step;
  logic sw_step_en;
  logic sw_power;
  logic core_en;
  logic core_clk;
  logic game_clk;
  logic step_active;
  logic reset_init;
  logic sys_reset;
  logic clk_slow;
  logic clk_fast;

  modport master (
    output sw_step, sw_step_en, sw_power,
    input  core_en, core_clk, game_clk, step_active,
    input  reset_init, sys_reset, clk_slow, clk_fast
  );

  modport slave (
    input  sw_step, sw_step_en, sw_power,
    output core_en, core_clk, game_clk, step_active,
    output reset_init, sys_reset, clk_slow, clk_fast
  );
endinterface

// File: rtl/fpgaboy_clock_gen.sv
// rtl/fpgaboy_clock_gen.sv - core divider, game clock mux, resets and slow clocks; step mux built under STEP_CLOCK_EN
module fpgaboy_clock_gen #(
  parameter int CORE_DIV       = 3,
  parameter int INIT_TICKS     = 16,
  parameter int DEBOUNCE_DELAY = 333333,
  parameter int DIV_SLOW       = 33333,
  parameter int DIV_FAST       = 166
) (
  input  logic                clock,
  input  logic                reset_n,
  fpgaboy_clock_gen_if.slave  bus
);

  localparam int PH_W    = $clog2(CORE_DIV);
  localparam int CORE_HI = ((CORE_DIV / 2) > 1) ? (CORE_DIV / 2) : 1;
  localparam int INIT_W  = $clog2(INIT_TICKS + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_DELAY + 1);
  localparam int SLOW_W  = $clog2(DIV_SLOW + 1);
  localparam int FAST_W  = $clog2(DIV_FAST + 1);

  // Switch index 0 is power; 1 and 2 (step_en, step) exist only with the step mux.
`ifdef STEP_CLOCK_EN
  localparam int NSW = 3;
`else
  localparam int NSW = 1;
`endif

  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_nxt;
  logic              r_core_en;
  logic              r_core_clk;
  logic [INIT_W-1:0] r_init_cnt;
  logic              r_reset_init;
  logic              r_sys_reset;
  logic [NSW-1:0]    w_sw_raw;
  logic [NSW-1:0]    r_sync1;
  logic [NSW-1:0]    r_sync2;
  logic [NSW-1:0]    r_new;
  logic [NSW-1:0]    r_clean;
  logic [DB_W-1:0]   r_count [NSW];
  logic              r_game_clk;
  logic [SLOW_W-1:0] r_slow_cnt;
  logic              r_clk_slow;
  logic [FAST_W-1:0] r_fast_cnt;
  logic              r_clk_fast;

`ifdef STEP_CLOCK_EN
  assign w_sw_raw = {bus.sw_step, bus.sw_step_en, bus.sw_power};
`else
  assign w_sw_raw = bus.sw_power;
`endif

  // Next phase of the reference-clock divider, wrapping at CORE_DIV-1.
  always_comb begin
    w_phase_nxt = r_phase + 1'b1;
    if (r_phase == PH_W'(CORE_DIV - 1)) begin
      w_phase_nxt = '0;
    end
  end

  // Phase counter plus registered tick and core clock, both aligned to the phase they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase    <= '0;
      r_core_en  <= 1'b0;
      r_core_clk <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_core_en  <= (w_phase_nxt == '0);
      r_core_clk <= (w_phase_nxt < PH_W'(CORE_HI));
    end
  end

  // Power-on reset: released on the INIT_TICKS-th core tick after reset_n goes high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init_cnt   <= '0;
      r_reset_init <= 1'b1;
    end else if (r_core_en && r_reset_init) begin
      if (r_init_cnt == INIT_W'(INIT_TICKS - 1)) begin
        r_reset_init <= 1'b0;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // Two-flop synchronisers every clock; debouncers advance on core ticks only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_new   <= '0;
      r_clean <= '0;
      for (int i = 0; i < NSW; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      r_sync1 <= w_sw_raw;
      r_sync2 <= r_sync1;
      if (r_core_en) begin
        for (int i = 0; i < NSW; i++) begin
          if (r_reset_init) begin
            r_new[i]   <= r_sync2[i];
            r_clean[i] <= r_sync2[i];
            r_count[i] <= '0;
          end else if (r_sync2[i] != r_new[i]) begin
            r_new[i]   <= r_sync2[i];
            r_count[i] <= '0;
          end else if (r_count[i] == DB_W'(DEBOUNCE_DELAY)) begin
            r_clean[i] <= r_new[i];
          end else begin
            r_count[i] <= r_count[i] + 1'b1;
          end
        end
      end
    end
  end

  // System reset combines power-on reset with a debounced power-off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sys_reset <= 1'b1;
    end else begin
      r_sys_reset <= r_reset_init | ~r_clean[0];
    end
  end

`ifdef STEP_CLOCK_EN
  logic r_step_active;
  logic w_cur_src;
  logic w_new_src;

  // Current source follows the select in effect; incoming source follows the requested select.
  always_comb begin
    w_cur_src = r_step_active ? r_clean[2] : r_core_clk;
    w_new_src = r_clean[1] ? r_clean[2] : r_core_clk;
  end

  // Select only changes while both the output and the incoming source are low, so no runt pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_game_clk    <= 1'b0;
      r_step_active <= 1'b0;
    end else begin
      r_game_clk <= w_cur_src;
      if (!r_game_clk && !w_new_src) begin
        r_step_active <= r_clean[1];
      end
    end
  end

  assign bus.step_active = r_step_active;
`else
  // Without the step mux the game clock is the core clock one reference clock later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_game_clk <= 1'b0;
    end else begin
      r_game_clk <= r_core_clk;
    end
  end

  assign bus.step_active = 1'b0;
`endif

  // Slow joypad clock: toggles every DIV_SLOW core ticks once power-on reset is done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slow_cnt <= '0;
      r_clk_slow <= 1'b0;
    end else if (r_reset_init) begin
      r_slow_cnt <= '0;
      r_clk_slow <= 1'b0;
    end else if (r_core_en) begin
      if (r_slow_cnt == SLOW_W'(DIV_SLOW - 1)) begin
        r_slow_cnt <= '0;
        r_clk_slow <= ~r_clk_slow;
      end else begin
        r_slow_cnt <= r_slow_cnt + 1'b1;
      end
    end
  end

  // Fast SPI debug clock: toggles every DIV_FAST core ticks once power-on reset is done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fast_cnt <= '0;
      r_clk_fast <= 1'b0;
    end else if (r_reset_init) begin
      r_fast_cnt <= '0;
      r_clk_fast <= 1'b0;
    end else if (r_core_en) begin
      if (r_fast_cnt == FAST_W'(DIV_FAST - 1)) begin
        r_fast_cnt <= '0;
        r_clk_fast <= ~r_clk_fast;
      end else begin
        r_fast_cnt <= r_fast_cnt + 1'b1;
      end
    end
  end

  assign bus.core_en    = r_core_en;
  assign bus.core_clk   = r_core_clk;
  assign bus.game_clk   = r_game_clk;
  assign bus.reset_init = r_reset_init;
  assign bus.sys_reset  = r_sys_reset;
  assign bus.clk_slow   = r_clk_slow;
  assign bus.clk_fast   = r_clk_fast;

endmodule

// File: tb/tb_fpgaboy_clock_gen.sv
// tb/tb_fpgaboy_clock_gen.sv - table-driven scoreboard bench for fpgaboy_clock_gen
module tb_fpgaboy_clock_gen;

  localparam int CORE_DIV = 3;
  localparam int INIT     = 4;
  localparam int DELAY    = 4;
  localparam int SLOW     = 5;
  localparam int FAST     = 2;
  localparam int CORE_HI  = 1;
`ifdef STEP_CLOCK_EN
  localparam bit STEP_BUILT = 1'b1;
`else
  localparam bit STEP_BUILT = 1'b0;
`endif

  typedef logic [7:0] vec_t;
  // {core_en, core_clk, game_clk, step_active, reset_init, sys_reset, clk_slow, clk_fast}
  localparam vec_t RESET_VEC = 8'b0000_1100;

  typedef struct {
    logic pw;
    logic en;
    logic st;
    int   cycles;
    logic exp_ri;
    logic exp_sr;
    logic exp_sa;
  } row_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  fpgaboy_clock_gen_if bus ();

  fpgaboy_clock_gen #(
    .CORE_DIV       (CORE_DIV),
    .INIT_TICKS     (INIT),
    .DEBOUNCE_DELAY (DELAY),
    .DIV_SLOW       (SLOW),
    .DIV_FAST       (FAST)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  vec_t       exp_q[$];
  logic [2:0] hist[$];
  int         m_n, m_ticks, m_div_ticks;
  logic       m_core_en, m_core_clk, m_game, m_sa, m_ri, m_sr, m_slow, m_fast;
  logic [2:0] m_clean, m_last;
  int         m_run [3];

  function automatic vec_t dut_vec();
    return {bus.core_en, bus.core_clk, bus.game_clk, bus.step_active,
            bus.reset_init, bus.sys_reset, bus.clk_slow, bus.clk_fast};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_n = 0; m_ticks = 0; m_div_ticks = 0;
    m_core_en = 0; m_core_clk = 0; m_game = 0; m_sa = 0;
    m_ri = 1; m_sr = 1; m_slow = 0; m_fast = 0;
    m_clean = '0; m_last = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  // Predict the outputs after the next rising edge, given inputs {step, step_en, power}.
  task automatic model_edge(input logic [2:0] sw);
    logic       tick, p_ri, p_core_clk, p_game, p_sa, incoming;
    logic [2:0] p_clean, s;
    tick = m_core_en; p_ri = m_ri; p_core_clk = m_core_clk;
    p_game = m_game; p_sa = m_sa; p_clean = m_clean;
    hist.push_back(sw);
    m_n++;
    m_core_en  = (m_n % CORE_DIV) == 0;
    m_core_clk = (m_n % CORE_DIV) < CORE_HI;
    if (tick && m_n >= 3) begin
      s = hist[m_n - 3];
      for (int i = 0; i < 3; i++) begin
        if (p_ri) begin
          m_clean[i] = s[i]; m_last[i] = s[i]; m_run[i] = 1;
        end else if (s[i] != m_last[i]) begin
          m_last[i] = s[i]; m_run[i] = 1;
        end else begin
          m_run[i]++;
          if (m_run[i] >= DELAY + 2) m_clean[i] = m_last[i];
        end
      end
      m_ticks++;
      if (m_ticks >= INIT) m_ri = 0;
      if (!p_ri) begin
        m_div_ticks++;
        m_slow = ((m_div_ticks / SLOW) % 2) == 1;
        m_fast = ((m_div_ticks / FAST) % 2) == 1;
      end
    end
    m_sr = p_ri | ~p_clean[0];
    if (STEP_BUILT) begin
      m_game   = p_sa ? p_clean[2] : p_core_clk;
      incoming = p_clean[1] ? p_clean[2] : p_core_clk;
      if (!p_game && !incoming) m_sa = p_clean[1];
    end else begin
      m_game = p_core_clk;
      m_sa   = 1'b0;
    end
    exp_q.push_back({m_core_en, m_core_clk, m_game, m_sa, m_ri, m_sr, m_slow, m_fast});
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Drive one cycle at a falling edge, predict, and compare after the following rising edge.
  task automatic cycle(input logic pw, input logic en, input logic st);
    vec_t e;
    bus.sw_power = pw; bus.sw_step_en = en; bus.sw_step = st;
    model_edge({st, en, pw});
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty edge=%0d", m_n);
    end else begin
      e = exp_q.pop_front();
      if (dut_vec() !== e) begin
        errors++;
        $display("FAIL sb_edge%0d got=%b expected=%b", m_n, dut_vec(), e);
      end
    end
  endtask

  row_t rows[$];

  initial begin
    logic prev;
    int   last, interval;

    rows.push_back('{1, 0, 0, 12, 1, 1, 0});
    rows.push_back('{1, 0, 0,  2, 0, 0, 0});
    rows.push_back('{1, 0, 0, 60, 0, 0, 0});
    rows.push_back('{0, 0, 0,  9, 0, 0, 0});
    rows.push_back('{1, 0, 0, 30, 0, 0, 0});
    rows.push_back('{0, 0, 0, 24, 0, 1, 0});
    rows.push_back('{1, 0, 0, 30, 0, 0, 0});
    rows.push_back('{1, 1, 0, 30, 0, 0, STEP_BUILT});
    rows.push_back('{1, 1, 1, 24, 0, 0, STEP_BUILT});
    rows.push_back('{1, 1, 0, 24, 0, 0, STEP_BUILT});
    rows.push_back('{1, 1, 1, 24, 0, 0, STEP_BUILT});
    rows.push_back('{1, 0, 1, 30, 0, 0, STEP_BUILT});
    rows.push_back('{1, 0, 0, 30, 0, 0, 0});

    bus.sw_power = 1'b1; bus.sw_step_en = 1'b0; bus.sw_step = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_vals", int'(dut_vec()), int'(RESET_VEC));
    reset_n = 1'b1;

    for (int r = 0; r < rows.size(); r++) begin
      for (int c = 0; c < rows[r].cycles; c++) cycle(rows[r].pw, rows[r].en, rows[r].st);
      chk($sformatf("row%0d_reset_init", r), int'(bus.reset_init), int'(rows[r].exp_ri));
      chk($sformatf("row%0d_sys_reset", r), int'(bus.sys_reset), int'(rows[r].exp_sr));
      chk($sformatf("row%0d_step_active", r), int'(bus.step_active), int'(rows[r].exp_sa));
    end

    // clk_fast toggle spacing in reference clocks
    prev = bus.clk_fast; last = -1; interval = -1;
    for (int i = 0; i < 40 && interval < 0; i++) begin
      cycle(1, 0, 0);
      if (bus.clk_fast !== prev) begin
        if (last >= 0) interval = i - last;
        last = i; prev = bus.clk_fast;
      end
    end
    chk("clk_fast_half_period", interval, FAST * CORE_DIV);

    // clk_slow toggle spacing in reference clocks
    prev = bus.clk_slow; last = -1; interval = -1;
    for (int i = 0; i < 80 && interval < 0; i++) begin
      cycle(1, 0, 0);
      if (bus.clk_slow !== prev) begin
        if (last >= 0) interval = i - last;
        last = i; prev = bus.clk_slow;
      end
    end
    chk("clk_slow_half_period", interval, SLOW * CORE_DIV);

    // Asynchronous reset mid-count, then the power-up sequence again
    cycle(1, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("async_reset_immediate", int'(dut_vec()), int'(RESET_VEC));
    model_reset();
    exp_q.delete();
    @(negedge clock);
    chk("async_reset_held", int'(dut_vec()), int'(RESET_VEC));
    reset_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cycle(1, 0, 0);
      if (i == 2)  chk("core_en_before_first", int'(bus.core_en), 0);
      if (i == 3)  chk("first_core_en", int'(bus.core_en), 1);
      if (i == 12) chk("reset_init_edge12", int'(bus.reset_init), 1);
      if (i == 13) chk("reset_init_edge13", int'(bus.reset_init), 0);
      if (i == 13) chk("sys_reset_edge13", int'(bus.sys_reset), 1);
      if (i == 14) chk("sys_reset_edge14", int'(bus.sys_reset), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpgaboy_clock_gen.md
# fpgaboy_clock_gen

Clock and reset generator for the FPGABoy top level, written as portable RTL with no vendor DCM, BUFG or BUFGMUX primitives. From the single board reference clock it derives:
- the core-rate tick and clock (reference ÷3, 100 MHz → 33.33 MHz);
- a glitch-free game clock that selects between the core clock and a debounced manual step switch;
- the power-on and power-switch system reset;
- two slow toggling clocks for the joypad and SPI debug adapters.

## Interface
Parameters:
- CORE_DIV, 3: reference cycles per core tick (≥2).
- INIT_TICKS, 16: core ticks that reset_init stays high after reset release.
- DEBOUNCE_DELAY, 333333: core ticks an input must be stable before the clean output updates. Counter width is $clog2(DEBOUNCE_DELAY+1).
- DIV_SLOW, 33333: core ticks between toggles of clk_slow.
- DIV_FAST, 166: core ticks between toggles of clk_fast.

Ports:
- clock, in, 1: 100 MHz reference clock. This is the only clock; every register uses its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- sw_step, in, 1: raw step-clock switch.
- sw_step_en, in, 1: raw step-mode switch (1 = step mode).
- sw_power, in, 1: raw power switch (0 = off, forces reset).
- core_en, out, 1: one-clock pulse once every CORE_DIV clocks.
- core_clk, out, 1: registered core-rate clock.
- game_clk, out, 1: registered, glitch-free muxed game clock.
- step_active, out, 1: the step selection currently in effect.
- reset_init, out, 1: power-on reset, active-high.
- sys_reset, out, 1: reset_init OR debounced power-off.
- clk_slow, out, 1: toggling clock driven by the DIV_SLOW counter.
- clk_fast, out, 1: toggling clock driven by the DIV_FAST counter.

## Operation
Core divider:
- phase counter counts 0..CORE_DIV-1, then wraps to 0.
- core_en is registered high in cycles where phase==0.
- core_clk is registered high for phases 0..max(1,CORE_DIV/2)-1.
- All "core tick" logic below advances only on cycles with core_en=1.

Power-on reset:
- reset_init is 1 during reset.
- After reset, reset_init clears on the INIT_TICKS-th core tick.

Input synchronisation and debouncing:
- Each switch passes through a 2-flop synchroniser, then a debouncer.
- Debouncer state: new, clean, count.
- While reset_init=1, new and clean load the synchronised input on each tick and count is 0.
- Otherwise, on each tick:
  - if input≠new: new←input, count←0;
  - else if count==DEBOUNCE_DELAY: clean←new;
  - else count+1.
- A glitch shorter than the delay restarts the count and never reaches clean.

System reset:
- sys_reset = reset_init | ~clean(sw_power), registered.

Game clock mux:
- Sources: core_clk when step_active=0; clean(sw_step) when step_active=1.
- step_active loads clean(sw_step_en) only in a cycle where game_clk is 0 and the incoming source is 0. Otherwise the pending change waits.
- game_clk is registered: the selected source's value from the previous clock.

Slow clocks:
- Each divider counts core ticks while reset_init=0.
- When its counter reaches DIV_x-1, it wraps to 0 and toggles its output.
- Output period is therefore 2·DIV_x core ticks.
- While reset_init=1, counters and outputs are held at 0.

## Timing
- Reset values (reset_n=0):
  - phase 0; core_en, core_clk, game_clk, step_active, clk_slow, clk_fast at 0;
  - reset_init=1, sys_reset=1;
  - all debouncer state 0.
- First core_en occurs CORE_DIV clocks after reset release.
- Switch-to-clean latency is 2 clocks of synchronisation plus DEBOUNCE_DELAY+2 core ticks of stable input.
- game_clk lags its source by 1 clock.
- A select change completes within one source period, provided that source toggles.
- If select changes while the step switch is held high, the handover waits until both game_clk and the incoming source are low. game_clk never emits a pulse shorter than one reference clock.
- reset_n asserted mid-operation clears everything immediately, including a pending select change.

## Configuration
- STEP_CLOCK_EN defined:
  - step mux, sw_step and sw_step_en debouncers, and step_active logic are built.
- Undefined:
  - game_clk is core_clk delayed 1 clock;
  - step_active is tied to 0;
  - sw_step and sw_step_en are ignored and those debouncers are not built.

## Test plan
Run with CORE_DIV=3, INIT_TICKS=4, DEBOUNCE_DELAY=4, DIV_SLOW=5, DIV_FAST=2.
- Reset release → core_en pulses every 3 clocks; reset_init falls on the 4th core tick; sys_reset follows when sw_power=1.
- Free-running → clk_slow toggles every 5 core ticks (15 clocks); clk_fast toggles every 6 clocks.
- sw_power pulsed to 0 for 3 core ticks → sys_reset stays 0. Held at 0 for 8 core ticks → sys_reset rises after 2 sync clocks + 6 ticks.
- sw_step_en=1 with sw_step=0 → step_active rises at the next game_clk-low cycle; game_clk then tracks sw_step 1 clock after clean changes.
- sw_step_en changed to 0 while sw_step is held at 1 → step_active stays 1 until sw_step is released low; game_clk shows no pulse narrower than 1 clock.
- reset_n pulsed low mid-count → all outputs take reset values in the same cycle; sequencing restarts as in the first scenario.
